// File: rtl/branch_pkg.sv
// branch_pkg: shared prediction record type, counter width and saturating increment helper.
package branch_pkg;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
    } Pred_record;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction
endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: in-order store of in-flight prediction records; flush empties it at the next edge.
module pred_fifo
    import branch_pkg::*;
#(
    parameter int depth = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  Pred_record din_i,
    output Pred_record dout_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int PW = $clog2(depth);

    Pred_record     mem_q [depth];
    logic [PW-1:0]  wr_q, rd_q;
    logic [PW:0]    cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    // A push while full is only issued alongside a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (32'(cnt_q) == depth);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) assert (32'(cnt_q) <= depth) else $error("pred_fifo occupancy above depth");
    end
`endif
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: compares retiring instructions against their predictions, drives
// branch cache updates, redirects on mispredict and keeps performance counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int depth      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [addr_width-1:0] issue_pc,
    input  logic                  issue_pred_taken,
    input  logic [addr_width-1:0] issue_pred_target,
    output logic                  issue_ready,
    input  logic                  resolve_valid,
    input  logic                  resolve_is_branch,
    input  logic                  resolve_taken,
    input  logic [addr_width-1:0] resolve_target,
    output logic                  upd_taken,
    output logic                  upd_not_taken,
    output logic [addr_width-1:0] upd_pc,
    output logic [addr_width-1:0] upd_jump_vec,
    output logic                  mispredict,
    output logic [addr_width-1:0] correct_pc,
    output logic                  empty,
    output logic                  full,
    output logic                  err_underflow,
    output logic [CNT_W-1:0]      n_branches,
    output logic [CNT_W-1:0]      n_mispredicts
);
    Pred_record head, rec_in;
    logic pop, br_pop, mis, push;

    logic                  mis_d, mis_q, upd_t_d, upd_t_q, upd_nt_d, upd_nt_q, err_d, err_q;
    logic [addr_width-1:0] upd_pc_d, upd_pc_q, upd_jv_d, upd_jv_q, cpc_d, cpc_q;
    logic [CNT_W-1:0]      n_br_d, n_br_q, n_mis_d, n_mis_q;

    assign rec_in = '{pc: issue_pc, pred_taken: issue_pred_taken, pred_target: issue_pred_target};

    pred_fifo #(.depth(depth)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (mis),
        .din_i   (rec_in),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    assign issue_ready = !full;

    // A mispredict kills everything younger than the head, including a same-cycle push.
    always_comb begin
        pop    = resolve_valid && !empty;
        br_pop = pop && resolve_is_branch;
        mis    = pop && (resolve_is_branch
                 ? (head.pred_taken != resolve_taken) || (resolve_taken && head.pred_target != resolve_target)
                 : head.pred_taken);
        push   = issue_valid && !mis && (!full || pop);
    end

    always_comb begin
        mis_d    = mis;
        upd_t_d  = br_pop && resolve_taken;
        upd_nt_d = br_pop && !resolve_taken;
        upd_pc_d = br_pop ? head.pc : upd_pc_q;
        upd_jv_d = br_pop ? resolve_target : upd_jv_q;
        cpc_d    = !pop ? cpc_q
                 : (resolve_is_branch && resolve_taken) ? resolve_target
                 : head.pc + addr_width'(1);
        err_d    = err_q || (resolve_valid && empty);
        n_br_d   = sat_inc(n_br_q, br_pop);
        n_mis_d  = sat_inc(n_mis_q, mis);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q    <= 1'b0;
            upd_t_q  <= 1'b0;
            upd_nt_q <= 1'b0;
            upd_pc_q <= '0;
            upd_jv_q <= '0;
            cpc_q    <= '0;
            err_q    <= 1'b0;
            n_br_q   <= '0;
            n_mis_q  <= '0;
        end else begin
            mis_q    <= mis_d;
            upd_t_q  <= upd_t_d;
            upd_nt_q <= upd_nt_d;
            upd_pc_q <= upd_pc_d;
            upd_jv_q <= upd_jv_d;
            cpc_q    <= cpc_d;
            err_q    <= err_d;
            n_br_q   <= n_br_d;
            n_mis_q  <= n_mis_d;
        end
    end

    assign mispredict    = mis_q;
    assign upd_taken     = upd_t_q;
    assign upd_not_taken = upd_nt_q;
    assign upd_pc        = upd_pc_q;
    assign upd_jump_vec  = upd_jv_q;
    assign correct_pc    = cpc_q;
    assign err_underflow = err_q;
    assign n_branches    = n_br_q;
    assign n_mispredicts = n_mis_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) assert (!(upd_t_q && upd_nt_q)) else $error("both update pulses high");
    end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench; a reference queue model predicts each resolve's outputs.
module tb_branch_resolve;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset;
    logic        issue_valid, issue_pred_taken, issue_ready;
    logic [11:0] issue_pc, issue_pred_target;
    logic        resolve_valid, resolve_is_branch, resolve_taken;
    logic [11:0] resolve_target;
    logic        upd_taken, upd_not_taken, mispredict, empty, full, err_underflow;
    logic [11:0] upd_pc, upd_jump_vec, correct_pc;
    logic [15:0] n_branches, n_mispredicts;

    always #5 clk = ~clk;

    branch_resolve #(.addr_width(12), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .issue_pred_target(issue_pred_target), .issue_ready(issue_ready),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .upd_taken(upd_taken), .upd_not_taken(upd_not_taken), .upd_pc(upd_pc),
        .upd_jump_vec(upd_jump_vec), .mispredict(mispredict), .correct_pc(correct_pc),
        .empty(empty), .full(full), .err_underflow(err_underflow),
        .n_branches(n_branches), .n_mispredicts(n_mispredicts)
    );

    typedef struct {logic [11:0] pc; logic pt; logic [11:0] tgt;} rec_t;
    typedef struct {logic mis; logic [11:0] cpc; logic ut; logic unt; logic [11:0] upc; logic [11:0] ujv;} exp_t;

    rec_t        model[$];
    exp_t        sb[$];
    int          errors = 0, checks = 0;
    logic [15:0] m_br, m_mis;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [11:0] pc, input logic pt, input logic [11:0] ptg,
                        input logic rv, input logic br, input logic tk, input logic [11:0] tg);
        exp_t e;
        rec_t h;
        int   sz0;
        logic pop, push;
        e = '{0, 0, 0, 0, 0, 0};
        sz0 = model.size();
        issue_valid = iv; issue_pc = pc; issue_pred_taken = pt; issue_pred_target = ptg;
        resolve_valid = rv; resolve_is_branch = br; resolve_taken = tk; resolve_target = tg;
        check("issue_ready", issue_ready, sz0 < DEPTH);
        pop = rv && sz0 > 0;
        if (rv && sz0 == 0) m_err = 1'b1;
        if (pop) begin
            h = model.pop_front();
            if (br) begin
                e.mis = (h.pt != tk) || (tk && h.tgt != tg);
                e.ut = tk; e.unt = !tk; e.upc = h.pc; e.ujv = tg;
                if (m_br != 16'hFFFF) m_br++;
            end else e.mis = h.pt;
            e.cpc = (br && tk) ? tg : h.pc + 12'd1;
            if (e.mis && m_mis != 16'hFFFF) m_mis++;
        end
        push = iv && !e.mis && (sz0 < DEPTH || pop);
        if (e.mis) model.delete();
        if (push) model.push_back('{pc, pt, ptg});
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check("mispredict", mispredict, e.mis);
        check("upd_taken", upd_taken, e.ut);
        check("upd_not_taken", upd_not_taken, e.unt);
        if (e.mis) check("correct_pc", correct_pc, e.cpc);
        if (e.ut || e.unt) begin
            check("upd_pc", upd_pc, e.upc);
            check("upd_jump_vec", upd_jump_vec, e.ujv);
        end
        check("empty", empty, model.size() == 0);
        check("full", full, model.size() == DEPTH);
        check("err_underflow", err_underflow, m_err);
        check("n_branches", n_branches, m_br);
        check("n_mispredicts", n_mispredicts, m_mis);
    endtask

    task automatic issue(input logic [11:0] pc, input logic pt, input logic [11:0] ptg);
        step(1, pc, pt, ptg, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [11:0] tg);
        step(0, 0, 0, 0, 1, br, tk, tg);
    endtask

    task automatic model_reset();
        model.delete();
        m_br = 0; m_mis = 0; m_err = 0;
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 0; issue_pc = 0; issue_pred_taken = 0; issue_pred_target = 0;
        resolve_valid = 0; resolve_is_branch = 0; resolve_taken = 0; resolve_target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", issue_ready, 1);
        check("rst_pulses", {mispredict, upd_taken, upd_not_taken}, 0);
        check("rst_pcs", {correct_pc, upd_pc, upd_jump_vec}, 0);
        check("rst_counters", {n_branches, n_mispredicts}, 0);
        check("rst_err", err_underflow, 0);
        reset = 1'b0;

        issue(12'h010, 1, 12'h040); resolve(1, 1, 12'h040);
        issue(12'h020, 0, 12'h000); resolve(1, 1, 12'h080);
        issue(12'hFFF, 1, 12'h123); resolve(1, 0, 12'h000);
        issue(12'h100, 1, 12'h200); resolve(0, 0, 12'h000);
        issue(12'h110, 0, 12'h000); resolve(0, 0, 12'h000);
        issue(12'h120, 1, 12'h050); resolve(1, 1, 12'h060);
        issue(12'h130, 0, 12'h000); resolve(1, 0, 12'h777);

        for (int i = 0; i < 4; i++) issue(12'h200 + 12'(i), 0, 12'h000);
        check("fill_full", full, 1);
        issue(12'h2FF, 1, 12'h3FF);
        step(1, 12'h204, 0, 12'h000, 1, 1, 0, 12'h000);
        check("full_after_swap", full, 1);
        resolve(0, 0, 12'h000);
        step(1, 12'h2AA, 0, 12'h000, 1, 1, 1, 12'h300);
        check("flush_empty", empty, 1);

        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 3)));

        while (model.size() > 0) resolve(0, 0, 12'h000);
        resolve(1, 1, 12'h555);
        check("underflow_set", err_underflow, 1);
        issue(12'h400, 0, 12'h000);
        resolve(1, 0, 12'h000);
        check("underflow_sticky", err_underflow, 1);

        issue(12'h500, 0, 12'h000);
        issue(12'h501, 0, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_empty", empty, 1);
        check("async_rst_err", err_underflow, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;

        force dut.n_mis_q = 16'hFFFE;
        #1;
        release dut.n_mis_q;
        m_mis = 16'hFFFE;
        issue(12'h600, 1, 12'h010); resolve(0, 0, 12'h000);
        check("sat_reach", n_mispredicts, 16'hFFFF);
        issue(12'h610, 0, 12'h000); resolve(1, 1, 12'h020);
        check("sat_hold", n_mispredicts, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
